// File: rtl/ann_pkg.sv
// Shared definitions for the time-multiplexed hidden-layer neuron sequencer.
package ann_pkg;

   localparam int unsigned ANN_DATA_W    = 4;
   localparam int unsigned ANN_N_NEURONS = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage : ann_pkg

// File: rtl/neuron_weight_regs.sv
// Per-neuron weight masks and threshold: one write port, one async read port.
module neuron_weight_regs
   import ann_pkg::*;
#(
   parameter int unsigned N_NEURONS = ANN_N_NEURONS,
   parameter int unsigned DATA_W    = ANN_DATA_W,
   parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_w1,
   input  logic [DATA_W-1:0] i_w2,
   input  logic [DATA_W-1:0] i_test,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_w1_c,
   output logic [DATA_W-1:0] o_w2_c,
   output logic [DATA_W-1:0] o_test_c
);

   logic [DATA_W-1:0] r_w1   [N_NEURONS];
   logic [DATA_W-1:0] r_w2   [N_NEURONS];
   logic [DATA_W-1:0] r_test [N_NEURONS];

   // Per-entry address decode; addresses with no matching entry write nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(N_NEURONS); k++) begin
            r_w1[k]   <= '0;
            r_w2[k]   <= '0;
            r_test[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(N_NEURONS); k++) begin
            if (i_we && (i_waddr == IDX_W'(k))) begin
               r_w1[k]   <= i_w1;
               r_w2[k]   <= i_w2;
               r_test[k] <= i_test;
            end
         end
      end
   end

   assign o_w1_c   = r_w1[i_raddr];
   assign o_w2_c   = r_w2[i_raddr];
   assign o_test_c = r_test[i_raddr];

endmodule : neuron_weight_regs

// File: rtl/neuron_layer_sequencer.sv
// Evaluates N logical neurons on one shared neuron datapath, one neuron per cycle,
// and returns the packed layer result over a valid/ready handshake.
module neuron_layer_sequencer
   import ann_pkg::*;
#(
   parameter int unsigned N_NEURONS = ANN_N_NEURONS,
   parameter int unsigned DATA_W    = ANN_DATA_W,
   parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_we,
   input  logic [IDX_W-1:0]            cfg_addr,
   input  logic [DATA_W-1:0]           cfg_w1,
   input  logic [DATA_W-1:0]           cfg_w2,
   input  logic [DATA_W-1:0]           cfg_test,
   output logic                        cfg_ready,
   input  logic                        in_valid,
   input  logic [DATA_W-1:0]           in_data,
   output logic                        in_ready,
   output logic [DATA_W-1:0]           nrn_in,
   output logic [DATA_W-1:0]           nrn_w1,
   output logic [DATA_W-1:0]           nrn_w2,
   output logic [DATA_W-1:0]           nrn_test,
   input  logic [DATA_W-1:0]           nrn_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_NEURONS*DATA_W-1:0] out_data,
   output logic                        busy
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_sample;
   logic [DATA_W-1:0] r_slot [N_NEURONS];
   logic              w_accept;
   logic              w_capture;
   logic              w_cfg_we;
   logic [DATA_W-1:0] w_rd_w1;
   logic [DATA_W-1:0] w_rd_w2;
   logic [DATA_W-1:0] w_rd_test;

   neuron_weight_regs #(
      .N_NEURONS (N_NEURONS),
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W)
   ) u_regs (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_cfg_we),
      .i_waddr  (cfg_addr),
      .i_w1     (cfg_w1),
      .i_w2     (cfg_w2),
      .i_test   (cfg_test),
      .i_raddr  (r_idx),
      .o_w1_c   (w_rd_w1),
      .o_w2_c   (w_rd_w2),
      .o_test_c (w_rd_test)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state plus the shared-neuron drive, which only carries data in RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_cfg_we    = 1'b0;
      nrn_in      = '0;
      nrn_w1      = '0;
      nrn_w2      = '0;
      nrn_test    = '0;
      case (r_state)
         S_IDLE: begin
            w_cfg_we = cfg_we;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_capture = 1'b1;
            nrn_in    = r_sample;
            nrn_w1    = w_rd_w1;
            nrn_w2    = w_rd_w2;
            nrn_test  = w_rd_test;
            if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_sample <= '0;
         for (int k = 0; k < int'(N_NEURONS); k++) r_slot[k] <= '0;
      end else if (w_accept) begin
         r_sample <= in_data;
         r_idx    <= '0;
      end else if (w_capture) begin
         for (int k = 0; k < int'(N_NEURONS); k++) begin
            if (r_idx == IDX_W'(k)) r_slot[k] <= nrn_out;
         end
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
   end

   for (genvar k = 0; k < int'(N_NEURONS); k++) begin : g_pack
      assign out_data[k*DATA_W +: DATA_W] = r_slot[k];
   end

   assign cfg_ready = (r_state == S_IDLE);
   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_DONE);

endmodule : neuron_layer_sequencer

// File: tb/tb_neuron_layer_sequencer.sv
// Randomized and directed bench for neuron_layer_sequencer with a stub neuron (w1 ^ test).
module tb_neuron_layer_sequencer;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 4;
   localparam int unsigned IW = 2;
   localparam int unsigned N5 = 5;
   localparam int unsigned IW5 = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          cfg_we, cfg_ready, in_valid, in_ready, out_valid, out_ready, busy;
   logic [IW-1:0] cfg_addr;
   logic [DW-1:0] cfg_w1, cfg_w2, cfg_test, in_data;
   logic [DW-1:0] nrn_in, nrn_w1, nrn_w2, nrn_test, nrn_out;
   logic [N*DW-1:0] out_data;

   assign nrn_out = nrn_w1 ^ nrn_test;

   neuron_layer_sequencer #(.N_NEURONS(N), .DATA_W(DW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w1(cfg_w1), .cfg_w2(cfg_w2),
      .cfg_test(cfg_test), .cfg_ready(cfg_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .nrn_in(nrn_in), .nrn_w1(nrn_w1), .nrn_w2(nrn_w2), .nrn_test(nrn_test),
      .nrn_out(nrn_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   // Five-neuron instance so that out-of-range config addresses are representable.
   logic           d5_cfg_we, d5_cfg_ready, d5_in_valid, d5_in_ready, d5_out_valid, d5_out_ready, d5_busy;
   logic [IW5-1:0] d5_cfg_addr;
   logic [DW-1:0]  d5_cfg_w1, d5_cfg_w2, d5_cfg_test, d5_in_data;
   logic [DW-1:0]  d5_nrn_in, d5_nrn_w1, d5_nrn_w2, d5_nrn_test, d5_nrn_out;
   logic [N5*DW-1:0] d5_out_data;

   assign d5_nrn_out = d5_nrn_w1 ^ d5_nrn_test;

   neuron_layer_sequencer #(.N_NEURONS(N5), .DATA_W(DW)) u_dut5 (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(d5_cfg_we), .cfg_addr(d5_cfg_addr), .cfg_w1(d5_cfg_w1), .cfg_w2(d5_cfg_w2),
      .cfg_test(d5_cfg_test), .cfg_ready(d5_cfg_ready),
      .in_valid(d5_in_valid), .in_data(d5_in_data), .in_ready(d5_in_ready),
      .nrn_in(d5_nrn_in), .nrn_w1(d5_nrn_w1), .nrn_w2(d5_nrn_w2), .nrn_test(d5_nrn_test),
      .nrn_out(d5_nrn_out),
      .out_valid(d5_out_valid), .out_ready(d5_out_ready), .out_data(d5_out_data), .busy(d5_busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] m_w1 [N];
   logic [DW-1:0] m_w2 [N];
   logic [DW-1:0] m_test [N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] model_result();
      logic [N*DW-1:0] r;
      for (int k = 0; k < int'(N); k++) r[k*DW +: DW] = m_w1[k] ^ m_test[k];
      return r;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < int'(N); k++) begin
         m_w1[k] = '0; m_w2[k] = '0; m_test[k] = '0;
      end
   endfunction

   // Issued from IDLE; the model takes the write as the sequencer should.
   task automatic cfg_write(input logic [IW-1:0] a, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input logic [DW-1:0] t);
      cfg_we = 1'b1; cfg_addr = a; cfg_w1 = w1; cfg_w2 = w2; cfg_test = t;
      @(negedge clk);
      cfg_we = 1'b0;
      m_w1[a] = w1; m_w2[a] = w2; m_test[a] = t;
   endtask

   task automatic run_sample(input logic [DW-1:0] data, input int hold,
                             input bit drop_cfg, input bit poke_valid);
      logic [N*DW-1:0] exp;
      check("in_ready_idle", in_ready, 1'b1);
      check("cfg_ready_idle", cfg_ready, 1'b1);
      in_valid = 1'b1; in_data = data;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         check("run_busy", busy, 1'b1);
         check("run_in_ready", in_ready, 1'b0);
         check("run_cfg_ready", cfg_ready, 1'b0);
         check("run_out_valid", out_valid, 1'b0);
         check("nrn_in", nrn_in, data);
         check("nrn_w1", nrn_w1, m_w1[k]);
         check("nrn_w2", nrn_w2, m_w2[k]);
         check("nrn_test", nrn_test, m_test[k]);
         if (drop_cfg && k == 1) begin
            cfg_we = 1'b1; cfg_addr = 2'd2; cfg_w1 = 4'hF; cfg_w2 = 4'hF; cfg_test = 4'h0;
         end
         @(negedge clk);
         cfg_we = 1'b0;
      end
      exp = model_result();
      check("done_out_valid", out_valid, 1'b1);
      check("done_out_data", out_data, exp);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         if (poke_valid && h == 2) begin
            in_valid = 1'b1; in_data = ~data;
         end
         @(negedge clk);
         in_valid = 1'b0;
         check("hold_out_valid", out_valid, 1'b1);
         check("hold_out_data", out_data, exp);
         check("hold_in_ready", in_ready, 1'b0);
         check("hold_nrn_w1", nrn_w1, '0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 1'b0);
      check("post_busy", busy, 1'b0);
      check("post_out_data", out_data, exp);
   endtask

   initial begin
      int acc[$];
      int last_acc;
      rst_n = 1'b0;
      cfg_we = 0; cfg_addr = '0; cfg_w1 = '0; cfg_w2 = '0; cfg_test = '0;
      in_valid = 0; in_data = '0; out_ready = 0;
      d5_cfg_we = 0; d5_cfg_addr = '0; d5_cfg_w1 = '0; d5_cfg_w2 = '0; d5_cfg_test = '0;
      d5_in_valid = 0; d5_in_data = '0; d5_out_ready = 0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_in_ready", in_ready, 1'b1);
      check("rst_cfg_ready", cfg_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_nrn", {nrn_in, nrn_w1, nrn_w2, nrn_test}, '0);
      check("rst_out_data", out_data, '0);

      // Directed: one-hot weights give 16'h9421.
      cfg_write(2'd0, 4'h1, 4'h0, 4'h0);
      cfg_write(2'd1, 4'h2, 4'h0, 4'h0);
      cfg_write(2'd2, 4'h4, 4'h0, 4'h0);
      cfg_write(2'd3, 4'h8, 4'h0, 4'h1);
      check("directed_model", model_result(), 16'h9421);
      run_sample(4'hF, 0, 1'b0, 1'b0);
      run_sample(4'hF, 10, 1'b0, 1'b1);
      run_sample(4'hF, 1, 1'b1, 1'b0);

      // Reset during the second RUN cycle.
      in_valid = 1'b1; in_data = 4'hA;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_clear();
      check("midrst_busy", busy, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_nrn", {nrn_in, nrn_w1, nrn_w2, nrn_test}, '0);
      check("midrst_out_data", out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_sample(4'h7, 0, 1'b0, 1'b0);
      check("midrst_result_zero", out_data, '0);

      // Random configuration, samples and backpressure.
      for (int it = 0; it < 16; it++) begin
         int nw;
         nw = int'($urandom_range(0, 3));
         for (int w = 0; w < nw; w++)
            cfg_write(IW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
         run_sample(DW'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      end

      // Back-to-back issue with in_valid and out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 4 * int'(N + 2); cyc++) begin
         in_data = DW'($urandom);
         if (in_ready) acc.push_back(cyc);
         if (out_valid) check("b2b_out_data", out_data, model_result());
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (N + 3) @(negedge clk);
      out_ready = 1'b0;
      check("b2b_idle", busy, 1'b0);
      check("b2b_accept_count", 32'(acc.size()), 32'd4);
      last_acc = -1;
      foreach (acc[i]) begin
         if (last_acc >= 0) check("b2b_interval", 32'(acc[i] - last_acc), 32'(N + 2));
         last_acc = acc[i];
      end

      // Five-neuron instance: out-of-range addresses 5..7 must not land anywhere.
      for (int k = 0; k < int'(N5); k++) begin
         d5_cfg_we = 1'b1; d5_cfg_addr = IW5'(k); d5_cfg_w1 = DW'(k + 1);
         d5_cfg_w2 = '0; d5_cfg_test = '0;
         @(negedge clk);
      end
      for (int k = int'(N5); k < 8; k++) begin
         d5_cfg_we = 1'b1; d5_cfg_addr = IW5'(k); d5_cfg_w1 = 4'hF; d5_cfg_test = 4'hC;
         @(negedge clk);
      end
      d5_cfg_we = 1'b0;
      d5_in_valid = 1'b1; d5_in_data = 4'h3;
      @(negedge clk);
      d5_in_valid = 1'b0;
      repeat (N5) @(negedge clk);
      check("d5_out_valid", d5_out_valid, 1'b1);
      check("d5_out_data", d5_out_data, 20'h54321);
      d5_out_ready = 1'b1;
      @(negedge clk);
      d5_out_ready = 1'b0;
      check("d5_idle", d5_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_neuron_layer_sequencer
